// File: rtl/axi_rd_burst_split.sv
// AXI4 read burst splitter: issues long INCR bursts as MAX_BURST_LEN-beat chunks
// and merges the returned R beats back into a single response with one rlast.
module axi_rd_burst_split #(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned ID_WIDTH      = 5,
    parameter int unsigned USER_WIDTH    = 1,
    parameter int unsigned MAX_BURST_LEN = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // slave AR
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arlock,
    input  logic [3:0]            s_axi_arcache,
    input  logic [2:0]            s_axi_arprot,
    input  logic [3:0]            s_axi_arqos,
    input  logic [3:0]            s_axi_arregion,
    input  logic [USER_WIDTH-1:0] s_axi_aruser,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    // slave R
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic [USER_WIDTH-1:0] s_axi_ruser,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    // master AR
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic [3:0]            m_axi_arqos,
    output logic [3:0]            m_axi_arregion,
    output logic [USER_WIDTH-1:0] m_axi_aruser,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    // master R
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic [USER_WIDTH-1:0] m_axi_ruser,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int unsigned CNT_W      = 9;
    localparam logic [CNT_W-1:0] MAX_BEATS  = CNT_W'(MAX_BURST_LEN);
    localparam logic [7:0]       MAX_LEN_M1 = 8'(MAX_BURST_LEN - 1);
    localparam logic [1:0]       BURST_INCR = 2'b01;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]            state_q,     state_d;
    logic                  arready_q,   arready_d;
    logic                  arvalid_q,   arvalid_d;
    logic                  rst_done_q,  rst_done_d;
    logic [ID_WIDTH-1:0]   id_q,        id_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [7:0]            len_q,       len_d;
    logic [2:0]            size_q,      size_d;
    logic [1:0]            burst_q,     burst_d;
    logic                  lock_q,      lock_d;
    logic [3:0]            cache_q,     cache_d;
    logic [2:0]            prot_q,      prot_d;
    logic [3:0]            qos_q,       qos_d;
    logic [3:0]            region_q,    region_d;
    logic [USER_WIDTH-1:0] user_q,      user_d;
    logic [CNT_W-1:0]      rem_issue_q, rem_issue_d;
    logic [CNT_W-1:0]      rem_beats_q, rem_beats_d;

    logic                  r_active_c;
    logic                  s_ar_hs_c;
    logic                  m_ar_hs_c;
    logic                  r_hs_c;
    logic [CNT_W-1:0]      total_c;
    logic [CNT_W-1:0]      chunk_c;
    logic [CNT_W-1:0]      rem_next_c;
    logic                  unused_m_rlast;

    // The beat count alone decides where the merged burst ends.
    assign unused_m_rlast = m_axi_rlast;

    assign r_active_c = rst_n && (state_q != IDLE);
    assign s_ar_hs_c  = s_axi_arvalid && arready_q;
    assign m_ar_hs_c  = arvalid_q && m_axi_arready;
    assign r_hs_c     = r_active_c && m_axi_rvalid && s_axi_rready;
    assign total_c    = {1'b0, s_axi_arlen} + CNT_W'(1);
    assign chunk_c    = {1'b0, len_q} + CNT_W'(1);
    assign rem_next_c = rem_issue_q - chunk_c;

    // Next-state and register-input logic
    always_comb begin
        state_d     = state_q;
        rst_done_d  = 1'b1;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        burst_d     = burst_q;
        lock_d      = lock_q;
        cache_d     = cache_q;
        prot_d      = prot_q;
        qos_d       = qos_q;
        region_d    = region_q;
        user_d      = user_q;
        rem_issue_d = rem_issue_q;
        rem_beats_d = rem_beats_q;

        if (r_hs_c) begin
            rem_beats_d = rem_beats_q - CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (s_ar_hs_c) begin
                    id_d        = s_axi_arid;
                    addr_d      = s_axi_araddr;
                    size_d      = s_axi_arsize;
                    burst_d     = s_axi_arburst;
                    lock_d      = s_axi_arlock;
                    cache_d     = s_axi_arcache;
                    prot_d      = s_axi_arprot;
                    qos_d       = s_axi_arqos;
                    region_d    = s_axi_arregion;
                    user_d      = s_axi_aruser;
                    rem_issue_d = total_c;
                    rem_beats_d = total_c;
                    // Only long INCR bursts get chunked; everything else keeps its len.
                    if ((s_axi_arburst == BURST_INCR) && (total_c > MAX_BEATS)) begin
                        len_d = MAX_LEN_M1;
                    end else begin
                        len_d = s_axi_arlen;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (m_ar_hs_c) begin
                    addr_d      = addr_q + (ADDR_WIDTH'(chunk_c) << size_q);
                    rem_issue_d = rem_next_c;
                    if (rem_next_c == '0) begin
                        state_d = DRAIN;
                    end else if (rem_next_c > MAX_BEATS) begin
                        len_d = MAX_LEN_M1;
                    end else begin
                        len_d = 8'(rem_next_c - CNT_W'(1));
                    end
                end
            end
            DRAIN: begin
                if (r_hs_c && (rem_beats_q == CNT_W'(1))) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        arvalid_d = (state_d == ISSUE);
        // Hold AR ready low for one extra cycle after reset release.
        arready_d = rst_done_q && (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            arready_q   <= 1'b0;
            arvalid_q   <= 1'b0;
            rst_done_q  <= 1'b0;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            lock_q      <= 1'b0;
            cache_q     <= '0;
            prot_q      <= '0;
            qos_q       <= '0;
            region_q    <= '0;
            user_q      <= '0;
            rem_issue_q <= '0;
            rem_beats_q <= '0;
        end else begin
            state_q     <= state_d;
            arready_q   <= arready_d;
            arvalid_q   <= arvalid_d;
            rst_done_q  <= rst_done_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            lock_q      <= lock_d;
            cache_q     <= cache_d;
            prot_q      <= prot_d;
            qos_q       <= qos_d;
            region_q    <= region_d;
            user_q      <= user_d;
            rem_issue_q <= rem_issue_d;
            rem_beats_q <= rem_beats_d;
        end
    end

    assign s_axi_arready  = arready_q;
    assign m_axi_arvalid  = arvalid_q;
    assign m_axi_arid     = id_q;
    assign m_axi_araddr   = addr_q;
    assign m_axi_arlen    = len_q;
    assign m_axi_arsize   = size_q;
    assign m_axi_arburst  = burst_q;
    assign m_axi_arlock   = lock_q;
    assign m_axi_arcache  = cache_q;
    assign m_axi_arprot   = prot_q;
    assign m_axi_arqos    = qos_q;
    assign m_axi_arregion = region_q;
    assign m_axi_aruser   = user_q;

    // R beats flow straight through while a burst is in flight.
    assign s_axi_rvalid = r_active_c && m_axi_rvalid;
    assign m_axi_rready = r_active_c && s_axi_rready;
    assign s_axi_rid    = m_axi_rid;
    assign s_axi_rdata  = m_axi_rdata;
    assign s_axi_rresp  = m_axi_rresp;
    assign s_axi_ruser  = m_axi_ruser;
    assign s_axi_rlast  = r_active_c && (rem_beats_q == CNT_W'(1));

endmodule

// File: tb/tb_axi_rd_burst_split.sv
// Bench for axi_rd_burst_split: a DDR-side responder model plus AR/R scoreboards.
module tb_axi_rd_burst_split;

    localparam int MAXB = 16;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [26:0] attr;
    } ar_t;

    typedef struct packed {
        logic [4:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        user;
        logic        last;
    } r_t;

    logic        clk, rst_n;
    logic [4:0]  s_axi_arid;
    logic [31:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic [2:0]  s_axi_arsize;
    logic [1:0]  s_axi_arburst;
    logic        s_axi_arlock;
    logic [3:0]  s_axi_arcache;
    logic [2:0]  s_axi_arprot;
    logic [3:0]  s_axi_arqos;
    logic [3:0]  s_axi_arregion;
    logic        s_axi_aruser;
    logic        s_axi_arvalid, s_axi_arready;
    logic [4:0]  s_axi_rid;
    logic [63:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast, s_axi_ruser, s_axi_rvalid, s_axi_rready;
    logic [4:0]  m_axi_arid;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arlock;
    logic [3:0]  m_axi_arcache;
    logic [2:0]  m_axi_arprot;
    logic [3:0]  m_axi_arqos;
    logic [3:0]  m_axi_arregion;
    logic        m_axi_aruser;
    logic        m_axi_arvalid, m_axi_arready;
    logic [4:0]  m_axi_rid;
    logic [63:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast, m_axi_ruser, m_axi_rvalid, m_axi_rready;

    int   errors = 0;
    int   checks = 0;
    ar_t  exp_ar_q[$];
    r_t   exp_r_q[$];
    int   tot_q[$];
    int   pend_q[$];
    int   bursts_done = 0;
    int   ar_seen = 0;
    logic [4:0] cur_id = '0;
    bit   stall_en = 0, rr_toggle = 0, rv_gap = 0, stray_en = 0;
    int   err_beat = -1;

    axi_rd_burst_split #(
        .ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(5), .USER_WIDTH(1), .MAX_BURST_LEN(MAXB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
        .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
        .s_axi_arregion(s_axi_arregion), .s_axi_aruser(s_axi_aruser),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_ruser(s_axi_ruser),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arregion(m_axi_arregion), .m_axi_aruser(m_axi_aruser),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_ruser(m_axi_ruser),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Downstream model and output monitor: sample at negedge, drive at posedge+1.
    initial begin : env
        bit  ar_hs, r_hs, arv_seen, stray_was;
        int  chunk_left, orig_left, orig_total, bidx, stall_cnt;
        ar_t ea;
        r_t  er;
        chunk_left = 0; orig_left = 0; orig_total = 0; stall_cnt = 0; stray_was = 0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rid = '0; m_axi_rdata = '0;
        m_axi_rresp = '0; m_axi_rlast = 1'b0; m_axi_ruser = 1'b0; s_axi_rready = 1'b1;
        forever begin
            @(negedge clk);
            arv_seen = m_axi_arvalid;
            ar_hs    = m_axi_arvalid && m_axi_arready;
            r_hs     = m_axi_rvalid && m_axi_rready;
            if (rst_n) begin
                if (m_axi_arvalid) begin
                    if (exp_ar_q.size() == 0) begin
                        check("ar_unexpected", m_axi_arvalid, 0);
                    end else begin
                        ea = exp_ar_q[0];
                        check("ar_addr", m_axi_araddr, ea.addr);
                        check("ar_len", m_axi_arlen, ea.len);
                        check("ar_attr", {m_axi_arid, m_axi_arsize, m_axi_arburst, m_axi_arlock,
                              m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arregion,
                              m_axi_aruser}, ea.attr);
                        if (m_axi_arready) void'(exp_ar_q.pop_front());
                    end
                    if (ar_hs) begin
                        ar_seen++;
                        pend_q.push_back(int'(m_axi_arlen) + 1);
                    end
                end
                if (s_axi_rvalid && s_axi_rready) begin
                    if (exp_r_q.size() == 0) begin
                        check("r_unexpected", s_axi_rvalid, 0);
                    end else begin
                        er = exp_r_q.pop_front();
                        check("r_data", s_axi_rdata, er.data);
                        check("r_resp", s_axi_rresp, er.resp);
                        check("r_id", s_axi_rid, er.id);
                        check("r_user", s_axi_ruser, er.user);
                        check("r_last", s_axi_rlast, er.last);
                        if (er.last) bursts_done++;
                    end
                end
            end
            @(posedge clk);
            #1;
            if (!rst_n) begin
                pend_q.delete(); tot_q.delete(); exp_ar_q.delete(); exp_r_q.delete();
                chunk_left = 0; orig_left = 0; m_axi_rvalid = 1'b0;
            end else begin
                if (!stall_en) begin
                    m_axi_arready = 1'b1;
                end else if (ar_hs || !arv_seen) begin
                    m_axi_arready = 1'b0;
                    stall_cnt = 0;
                end else if (!m_axi_arready) begin
                    stall_cnt++;
                    if (stall_cnt >= 5) m_axi_arready = 1'b1;
                end
                if (r_hs || (stray_was && !stray_en)) m_axi_rvalid = 1'b0;
                if (stray_en) begin
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata  = {$urandom, $urandom};
                end else if (!m_axi_rvalid && (chunk_left > 0 || pend_q.size() > 0)
                             && (!rv_gap || $urandom_range(0, 1) == 1)) begin
                    if (chunk_left == 0) chunk_left = pend_q.pop_front();
                    if (orig_left == 0 && tot_q.size() > 0) begin
                        orig_left  = tot_q.pop_front();
                        orig_total = orig_left;
                    end
                    bidx = orig_total - orig_left;
                    m_axi_rdata = {$urandom, $urandom};
                    m_axi_rresp = (bidx == err_beat) ? 2'b10 : 2'b00;
                    m_axi_rid   = cur_id;
                    m_axi_ruser = 1'($urandom);
                    // With gaps enabled the downstream rlast is scrambled to prove it is ignored.
                    m_axi_rlast = rv_gap ? 1'($urandom) : (chunk_left == 1);
                    chunk_left--;
                    orig_left--;
                    er.id = m_axi_rid; er.data = m_axi_rdata; er.resp = m_axi_rresp;
                    er.user = m_axi_ruser; er.last = (orig_left == 0);
                    exp_r_q.push_back(er);
                    m_axi_rvalid = 1'b1;
                end
                stray_was    = stray_en;
                s_axi_rready = rr_toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    task automatic send_ar(input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        ar_t e;
        int total, rem, c, cyc;
        logic [31:0] a;
        bit split;
        cyc = 0;
        while (s_axi_arready !== 1'b1 && cyc < 500) begin
            @(posedge clk); #1; cyc++;
        end
        check("ar_accept_ready", s_axi_arready, 1);
        s_axi_arid = 5'($urandom); s_axi_arlock = 1'($urandom); s_axi_arcache = 4'($urandom);
        s_axi_arprot = 3'($urandom); s_axi_arqos = 4'($urandom);
        s_axi_arregion = 4'($urandom); s_axi_aruser = 1'($urandom);
        s_axi_araddr = addr; s_axi_arlen = len; s_axi_arsize = size; s_axi_arburst = burst;
        cur_id = s_axi_arid;
        total = int'(len) + 1;
        split = (burst == 2'b01) && (total > MAXB);
        a = addr;
        rem = total;
        while (rem > 0) begin
            c = (split && rem > MAXB) ? MAXB : rem;
            e.addr = a;
            e.len  = 8'(c - 1);
            e.attr = {s_axi_arid, size, burst, s_axi_arlock, s_axi_arcache, s_axi_arprot,
                      s_axi_arqos, s_axi_arregion, s_axi_aruser};
            exp_ar_q.push_back(e);
            a = a + (32'(c) << size);
            rem -= c;
        end
        tot_q.push_back(total);
        s_axi_arvalid = 1'b1;
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int cyc;
        cyc = 0;
        while (bursts_done < target && cyc < 5000) begin
            @(posedge clk); #1; cyc++;
        end
        check("burst_done", bursts_done, target);
        check("r_queue_empty", exp_r_q.size(), 0);
        check("ar_queue_empty", exp_ar_q.size(), 0);
    endtask

    initial begin : test
        int nb, base, cyc;
        rst_n = 1'b0; s_axi_arvalid = 1'b0; s_axi_arid = '0; s_axi_araddr = '0;
        s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = '0; s_axi_arlock = 1'b0;
        s_axi_arcache = '0; s_axi_arprot = '0; s_axi_arqos = '0; s_axi_arregion = '0;
        s_axi_aruser = 1'b0;
        nb = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_arready", s_axi_arready, 0);
        check("rst_arvalid", m_axi_arvalid, 0);
        check("rst_rvalid", s_axi_rvalid, 0);
        check("rst_rready", m_axi_rready, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_arready_lo", s_axi_arready, 0);
        @(posedge clk); #1;
        check("post_rst_arready_hi", s_axi_arready, 1);

        send_ar(32'h0000_1000, 8'h3F, 3'd6, 2'b01); nb++; wait_done(nb);
        send_ar(32'h0000_2000, 8'h13, 3'd6, 2'b01); nb++; wait_done(nb);
        send_ar(32'h0000_3040, 8'h07, 3'd3, 2'b10); nb++; wait_done(nb);
        send_ar(32'h0000_4000, 8'h0F, 3'd2, 2'b00); nb++; wait_done(nb);
        send_ar(32'h0000_4100, 8'h3F, 3'd2, 2'b00); nb++; wait_done(nb);
        send_ar(32'h0000_4200, 8'h28, 3'd2, 2'b11); nb++; wait_done(nb);
        send_ar(32'h0000_5000, 8'h0F, 3'd4, 2'b01); nb++; wait_done(nb);
        send_ar(32'h0000_5100, 8'h10, 3'd4, 2'b01); nb++; wait_done(nb);
        send_ar(32'hFFFF_F800, 8'h2F, 3'd6, 2'b01); nb++; wait_done(nb);

        // Stray beat while idle must not be accepted or forwarded.
        stray_en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("stray_rready", m_axi_rready, 0);
        check("stray_rvalid", s_axi_rvalid, 0);
        stray_en = 1'b0;
        @(posedge clk); #1;

        stall_en = 1'b1; rr_toggle = 1'b1; rv_gap = 1'b1;
        send_ar(32'h0000_6000, 8'h2F, 3'd5, 2'b01); nb++; wait_done(nb);
        stall_en = 1'b0; rr_toggle = 1'b0; rv_gap = 1'b0;

        err_beat = 16;
        send_ar(32'h0000_7000, 8'h1F, 3'd6, 2'b01); nb++; wait_done(nb);
        err_beat = -1;

        base = ar_seen;
        send_ar(32'h0000_8000, 8'h3F, 3'd6, 2'b01);
        cyc = 0;
        while (ar_seen < base + 2 && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        check("mid_rst_chunks_seen", ar_seen - base, 2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_arvalid", m_axi_arvalid, 0);
        check("mid_rst_rvalid", s_axi_rvalid, 0);
        check("mid_rst_arready", s_axi_arready, 0);
        check("mid_rst_rready", m_axi_rready, 0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_arready_lo", s_axi_arready, 0);
        @(posedge clk); #1;
        check("mid_rst_arready_hi", s_axi_arready, 1);
        send_ar(32'h0000_9000, 8'h22, 3'd6, 2'b01); nb++; wait_done(nb);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
